// File: rtl/qs_pkg.sv
// qs_pkg: shared types for the quicksort engine stack and the SRAM signal-bundle macro.
`define LIBV_SPSRAM_SIGNALS(aw, dw) \
  logic ram_en; \
  logic ram_we; \
  logic [(aw)-1:0] ram_addr; \
  logic [(dw)-1:0] ram_din; \
  logic [(dw)-1:0] ram_dout;

package qs_pkg;
  typedef enum logic [1:0] {
    QS_PUSH = 2'd0,
    QS_POP  = 2'd1,
    QS_CLR  = 2'd2,
    QS_PEEK = 2'd3
  } qs_stk_op_t;
  localparam int QS_RSP_CTXW = 8;
  localparam int QS_RSP_W = 64;
  typedef struct packed {
    qs_stk_op_t op;
    logic [QS_RSP_CTXW-1:0] ctx;
    logic err;
    logic [QS_RSP_W-1:0] dat;
  } qs_stk_rsp_t;
endpackage

// File: rtl/spsram.sv
// spsram: single-port SRAM with optional asynchronous read data.
module spsram #(
    parameter int W = 32,
    parameter int N = 64,
    parameter int ASYNC_DOUT = 1
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] addr,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout
);
    logic [W-1:0] mem [N];
    always_ff @(posedge clk)
        if (en & we) mem[addr] <= din;
    if (ASYNC_DOUT != 0) begin : g_async
        assign dout = mem[addr];
    end else begin : g_sync
        logic [W-1:0] q;
        always_ff @(posedge clk)
            if (en & ~we) q <= mem[addr];
        assign dout = q;
    end
endmodule

// File: rtl/qs_mstack.sv
// qs_mstack: multi-context LIFO with per-context top cache over one shared async-read SRAM.
module qs_mstack
    import qs_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 16,
    parameter int NCTX = 4,
    localparam int CW = NCTX > 1 ? $clog2(NCTX) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [1:0]      cmd_op,
    input  logic [CW-1:0]   cmd_ctx,
    input  logic [W-1:0]    cmd_dat,
    output logic            rsp_vld_r,
    input  logic            rsp_rdy,
    output logic [1:0]      rsp_op_r,
    output logic [CW-1:0]   rsp_ctx_r,
    output logic            rsp_err_r,
    output logic [W-1:0]    rsp_dat_r,
    output logic [NCTX-1:0] empty_r,
    output logic [NCTX-1:0] full_r
);
    localparam int DW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int AW = $clog2(NCTX * N);

    `LIBV_SPSRAM_SIGNALS(AW, W)

    spsram #(.W(W), .N(NCTX * N), .ASYNC_DOUT(1)) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    logic [DW-1:0] cnt [NCTX];
    logic [DW-1:0] nxt_cnt [NCTX];
    logic [W-1:0]  top [NCTX];
    qs_stk_op_t    op;
    logic          acc, is_empty, is_full, rd_op, err, refill;
    logic [DW-1:0] cc;
    logic [IW-1:0] idx;
    logic [W-1:0]  rdat;

    assign cmd_rdy = ~rsp_vld_r | rsp_rdy;

    always_comb begin
        op       = qs_stk_op_t'(cmd_op);
        acc      = cmd_vld & cmd_rdy;
        cc       = cnt[cmd_ctx];
        is_empty = cc == '0;
        is_full  = cc == DW'(N);
        rd_op    = op == QS_POP || op == QS_PEEK;
        err      = op == QS_PUSH ? is_full : rd_op & is_empty;
        refill   = op == QS_POP && cc >= DW'(2);
        rdat     = rd_op & ~is_empty ? top[cmd_ctx] : '0;
        idx      = IW'(op == QS_PUSH ? cc - DW'(1) : cc - DW'(2));
        ram_we   = op == QS_PUSH;
        ram_en   = acc & (op == QS_PUSH ? ~is_full & ~is_empty : refill);
        ram_addr = AW'({cmd_ctx, idx});
        ram_din  = top[cmd_ctx];
        nxt_cnt  = cnt;
        if (acc)
            nxt_cnt[cmd_ctx] = op == QS_CLR ? '0 :
                               (err || op == QS_PEEK) ? cc :
                               op == QS_PUSH ? cc + DW'(1) : cc - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_r <= 1'b0;
            rsp_op_r  <= '0;
            rsp_ctx_r <= '0;
            rsp_err_r <= 1'b0;
            rsp_dat_r <= '0;
            for (int i = 0; i < NCTX; i++) cnt[i] <= '0;
            empty_r   <= '1;
            full_r    <= '0;
        end else begin
            if (acc) begin
                rsp_vld_r <= 1'b1;
                rsp_op_r  <= cmd_op;
                rsp_ctx_r <= cmd_ctx;
                rsp_err_r <= err;
                rsp_dat_r <= rdat;
            end else if (rsp_rdy) begin
                rsp_vld_r <= 1'b0;
            end
            for (int i = 0; i < NCTX; i++) begin
                cnt[i]     <= nxt_cnt[i];
                empty_r[i] <= nxt_cnt[i] == '0;
                full_r[i]  <= nxt_cnt[i] == DW'(N);
            end
        end
    end

    always_ff @(posedge clk)
        if (acc & ~err) begin
            if (op == QS_PUSH) top[cmd_ctx] <= cmd_dat;
            else if (refill) top[cmd_ctx] <= ram_dout;
        end
endmodule

// File: tb/tb_qs_mstack.sv
// tb_qs_mstack: directed stimulus checked against a per-context array/count stack model.
module tb_qs_mstack;
    import qs_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'd0;
    logic [1:0]  cmd_ctx = 2'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic        rsp_vld_r;
    logic        rsp_rdy = 1'b1;
    logic [1:0]  rsp_op_r;
    logic [1:0]  rsp_ctx_r;
    logic        rsp_err_r;
    logic [31:0] rsp_dat_r;
    logic [3:0]  empty_r;
    logic [3:0]  full_r;

    qs_mstack #(.W(32), .N(16), .NCTX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_op    (cmd_op),
        .cmd_ctx   (cmd_ctx),
        .cmd_dat   (cmd_dat),
        .rsp_vld_r (rsp_vld_r),
        .rsp_rdy   (rsp_rdy),
        .rsp_op_r  (rsp_op_r),
        .rsp_ctx_r (rsp_ctx_r),
        .rsp_err_r (rsp_err_r),
        .rsp_dat_r (rsp_dat_r),
        .empty_r   (empty_r),
        .full_r    (full_r)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each context is a plain array plus element count.
    logic [31:0] mst [4][16];
    int          mcnt [4];
    bit          exp_vld;
    qs_stk_rsp_t exp_rsp;
    qs_stk_rsp_t r;
    int          c;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) mcnt[k] = 0;
            exp_vld = 1'b0;
            exp_rsp = '0;
        end else if (cmd_vld && (!exp_vld || rsp_rdy)) begin
            c = int'(cmd_ctx);
            r = '0;
            r.op = qs_stk_op_t'(cmd_op);
            r.ctx = 8'(cmd_ctx);
            case (cmd_op)
                2'd0: if (mcnt[c] == 16) r.err = 1'b1;
                      else begin mst[c][mcnt[c]] = cmd_dat; mcnt[c]++; end
                2'd1: if (mcnt[c] == 0) r.err = 1'b1;
                      else begin mcnt[c]--; r.dat = 64'(mst[c][mcnt[c]]); end
                2'd2: mcnt[c] = 0;
                default: if (mcnt[c] == 0) r.err = 1'b1;
                         else r.dat = 64'(mst[c][mcnt[c]-1]);
            endcase
            exp_rsp = r;
            exp_vld = 1'b1;
        end else if (rsp_rdy) begin
            exp_vld = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rsp_vld", 64'(rsp_vld_r), 64'(exp_vld));
            chk("cmd_rdy", 64'(cmd_rdy), 64'(!exp_vld || rsp_rdy));
            if (exp_vld) begin
                chk("rsp_op", 64'(rsp_op_r), 64'(exp_rsp.op));
                chk("rsp_ctx", 64'(rsp_ctx_r), 64'(exp_rsp.ctx));
                chk("rsp_err", 64'(rsp_err_r), 64'(exp_rsp.err));
                chk("rsp_dat", 64'(rsp_dat_r), exp_rsp.dat);
            end
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("empty[%0d]", k), 64'(empty_r[k]), 64'(mcnt[k] == 0));
                chk($sformatf("full[%0d]", k), 64'(full_r[k]), 64'(mcnt[k] == 16));
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] ctx, input logic [31:0] dat);
        bit a = 1'b0;
        cmd_vld = 1'b1;
        cmd_op = op;
        cmd_ctx = ctx;
        cmd_dat = dat;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 20 && !a; i++) begin
            @(negedge clk);
            a = cmd_rdy;
            @(posedge clk);
            #1;
        end
        chk("accept", 64'(a), 64'd1);
        cmd_vld = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset rsp_vld", 64'(rsp_vld_r), 64'd0);
        chk("reset rsp_dat", 64'(rsp_dat_r), 64'd0);
        chk("reset empty", 64'(empty_r), 64'hF);
        chk("reset full", 64'(full_r), 64'h0);
        chk("reset cmd_rdy", 64'(cmd_rdy), 64'd1);
        rst = 1'b0;

        do_cmd(2'd0, 2'd0, 32'hA);
        do_cmd(2'd0, 2'd0, 32'hB);
        do_cmd(2'd0, 2'd0, 32'hC);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("pop0 C", 64'(rsp_dat_r), 64'hC);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("pop0 B", 64'(rsp_dat_r), 64'hB);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("pop0 A", 64'(rsp_dat_r), 64'hA);
        chk("pop0 err", 64'(rsp_err_r), 64'd0);
        chk("empty0", 64'(empty_r[0]), 64'd1);

        for (int i = 0; i < 16; i++) do_cmd(2'd0, 2'd1, 32'(100 + i));
        chk("full1", 64'(full_r[1]), 64'd1);
        do_cmd(2'd0, 2'd1, 32'd999);
        chk("overflow err", 64'(rsp_err_r), 64'd1);
        chk("overflow full", 64'(full_r[1]), 64'd1);
        do_cmd(2'd1, 2'd1, 32'h0);
        chk("pop 16th", 64'(rsp_dat_r), 64'd115);
        chk("full1 clear", 64'(full_r[1]), 64'd0);
        do_cmd(2'd2, 2'd1, 32'h0);

        do_cmd(2'd1, 2'd2, 32'h0);
        chk("underflow pop err", 64'(rsp_err_r), 64'd1);
        chk("underflow pop dat", 64'(rsp_dat_r), 64'd0);
        do_cmd(2'd3, 2'd2, 32'h0);
        chk("underflow peek err", 64'(rsp_err_r), 64'd1);
        do_cmd(2'd0, 2'd2, 32'h55);
        do_cmd(2'd3, 2'd2, 32'h0);
        chk("peek1", 64'(rsp_dat_r), 64'h55);
        do_cmd(2'd3, 2'd2, 32'h0);
        chk("peek2", 64'(rsp_dat_r), 64'h55);
        chk("peek keeps", 64'(empty_r[2]), 64'd0);
        do_cmd(2'd1, 2'd2, 32'h0);
        chk("pop after peek", 64'(rsp_dat_r), 64'h55);
        chk("empty2", 64'(empty_r[2]), 64'd1);

        do_cmd(2'd0, 2'd0, 32'd1);
        do_cmd(2'd0, 2'd3, 32'd2);
        do_cmd(2'd0, 2'd0, 32'd3);
        do_cmd(2'd0, 2'd3, 32'd4);
        do_cmd(2'd1, 2'd3, 32'h0);
        chk("ilv 4", 64'(rsp_dat_r), 64'd4);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("ilv 3", 64'(rsp_dat_r), 64'd3);
        do_cmd(2'd1, 2'd3, 32'h0);
        chk("ilv 2", 64'(rsp_dat_r), 64'd2);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("ilv 1", 64'(rsp_dat_r), 64'd1);

        do_cmd(2'd0, 2'd0, 32'h77);
        do_cmd(2'd3, 2'd0, 32'h0);
        rsp_rdy = 1'b0;
        cmd_vld = 1'b1;
        cmd_op = 2'd0;
        cmd_ctx = 2'd0;
        cmd_dat = 32'h88;
        repeat (5) @(posedge clk);
        #1;
        chk("stall cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("stall vld", 64'(rsp_vld_r), 64'd1);
        chk("stall op", 64'(rsp_op_r), 64'd3);
        chk("stall dat", 64'(rsp_dat_r), 64'h77);
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("resume op", 64'(rsp_op_r), 64'd0);
        cmd_vld = 1'b0;
        do_cmd(2'd0, 2'd0, 32'h99);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("resume 99", 64'(rsp_dat_r), 64'h99);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("resume 88", 64'(rsp_dat_r), 64'h88);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("resume 77", 64'(rsp_dat_r), 64'h77);
        do_cmd(2'd1, 2'd0, 32'h0);
        chk("resume empty err", 64'(rsp_err_r), 64'd1);

        do_cmd(2'd0, 2'd1, 32'h11);
        do_cmd(2'd0, 2'd1, 32'h22);
        do_cmd(2'd0, 2'd1, 32'h33);
        do_cmd(2'd2, 2'd1, 32'h0);
        chk("clr empty1", 64'(empty_r[1]), 64'd1);
        chk("clr err", 64'(rsp_err_r), 64'd0);
        do_cmd(2'd1, 2'd1, 32'h0);
        chk("pop after clr", 64'(rsp_err_r), 64'd1);

        do_cmd(2'd0, 2'd2, 32'h5);
        rsp_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst vld", 64'(rsp_vld_r), 64'd0);
        chk("midrst empty", 64'(empty_r), 64'hF);
        rst = 1'b0;
        rsp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
